// File: rtl/arbiter_ctrl.sv
// Single-resource arbiter for 8 requesters with a per-owner hold limit (MAX_HOLD).
// Define ARBITER_ROUND_ROBIN_EN for rotating priority; the default is fixed priority with req[0] highest.
module arbiter_ctrl #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] code,
    output logic       valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

    state_t     state_q, state_d;
    logic [7:0] gnt_q, gnt_d;
    logic [2:0] code_q, code_d;
    logic       valid_q, valid_d;
    logic       timeout_q, timeout_d;
    logic [7:0] cnt_q, cnt_d;

    logic [2:0] base;
    logic [2:0] idx;
    logic [2:0] sel;
    logic       hold_full;
    logic       release_c;

`ifdef ARBITER_ROUND_ROBIN_EN
    logic [2:0] ptr_q, ptr_d;
    assign base = ptr_q + 3'd1;
`else
    assign base = '0;
`endif

    // Scan from the lowest-priority slot up so the highest-priority hit is written last.
    always_comb begin
        sel = '0;
        idx = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            idx = base + 3'(7 - i);
            if (req[idx]) begin
                sel = idx;
            end
        end
    end

    assign hold_full = (cnt_q == HOLD_MAX);
    assign release_c = done | ~req[code_q] | hold_full;

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        code_d    = code_q;
        valid_d   = valid_q;
        timeout_d = 1'b0;
        cnt_d     = cnt_q;
`ifdef ARBITER_ROUND_ROBIN_EN
        ptr_d     = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                gnt_d   = '0;
                valid_d = 1'b0;
                cnt_d   = '0;
                if (|req) begin
                    state_d = BUSY;
                    gnt_d   = 8'b1 << sel;
                    code_d  = sel;
                    valid_d = 1'b1;
                    cnt_d   = 8'd1;
`ifdef ARBITER_ROUND_ROBIN_EN
                    ptr_d   = sel;
`endif
                end
            end
            BUSY: begin
                if (release_c) begin
                    state_d   = IDLE;
                    gnt_d     = '0;
                    valid_d   = 1'b0;
                    cnt_d     = '0;
                    timeout_d = hold_full & ~done & req[code_q];
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                valid_d = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            code_q    <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
`ifdef ARBITER_ROUND_ROBIN_EN
            ptr_q     <= 3'd7;
`endif
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
`ifdef ARBITER_ROUND_ROBIN_EN
            ptr_q     <= ptr_d;
`endif
        end
    end

    assign gnt     = gnt_q;
    assign code    = code_q;
    assign valid   = valid_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_arbiter_ctrl.sv
// Bench for arbiter_ctrl (MAX_HOLD=4): owner-level model checked every cycle,
// plus hand-computed expectations at specific cycles.
module tb_arbiter_ctrl;

    localparam int MH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] code;
    logic       valid;
    logic       timeout;

    int cmp_count = 0;
    int mis_count = 0;
    int cyc = 0;

    // Model state: current owner (-1 = none), cycles held, last granted index.
    int         m_owner = -1;
    int         m_held  = 0;
    int         m_last  = 7;
    logic [2:0] m_code  = 3'd0;
    logic       m_to    = 1'b0;

    bit         lit_on   [0:511];
    logic [7:0] lit_gnt  [0:511];
    logic [2:0] lit_code [0:511];
    logic       lit_valid[0:511];
    logic       lit_to   [0:511];

    arbiter_ctrl #(.MAX_HOLD(MH)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .done   (done),
        .gnt    (gnt),
        .code   (code),
        .valid  (valid),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int pick(input logic [7:0] r, input int last);
        int p;
        int k;
        p = -1;
        for (int i = 0; i < 8; i++) begin
`ifdef ARBITER_ROUND_ROBIN_EN
            k = (last + 1 + i) % 8;
`else
            k = i + 0 * last;
`endif
            if (p < 0 && r[k]) p = k;
        end
        return p;
    endfunction

    function automatic logic [7:0] onehot_of(input int o);
        return (o < 0) ? 8'h00 : 8'(1 << o);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner <= -1;
            m_held  <= 0;
            m_last  <= 7;
            m_code  <= 3'd0;
            m_to    <= 1'b0;
        end else if (m_owner < 0) begin
            m_to <= 1'b0;
            if (req != 8'h00) begin
                m_owner <= pick(req, m_last);
                m_last  <= pick(req, m_last);
                m_code  <= 3'(pick(req, m_last));
                m_held  <= 1;
            end
        end else if (done || !req[m_owner] || m_held == MH) begin
            m_to    <= (m_held == MH) && !done && req[m_owner];
            m_owner <= -1;
        end else begin
            m_to   <= 1'b0;
            m_held <= m_held + 1;
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        cmp_count++;
        if (act !== exp) begin
            mis_count++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cyc < 512 && lit_on[cyc]) begin
            check("lit.gnt", gnt, lit_gnt[cyc]);
            check("lit.code", {5'd0, code}, {5'd0, lit_code[cyc]});
            check("lit.valid", {7'd0, valid}, {7'd0, lit_valid[cyc]});
            check("lit.timeout", {7'd0, timeout}, {7'd0, lit_to[cyc]});
        end
        check("model.gnt", gnt, onehot_of(m_owner));
        check("model.code", {5'd0, code}, {5'd0, m_code});
        check("model.valid", {7'd0, valid}, {7'd0, 1'(m_owner >= 0)});
        check("model.timeout", {7'd0, timeout}, {7'd0, m_to});
    end

    task automatic expect_at(input int offs, input logic [7:0] g, input logic [2:0] c,
                             input logic v, input logic t);
        lit_on[cyc + offs]    = 1'b1;
        lit_gnt[cyc + offs]   = g;
        lit_code[cyc + offs]  = c;
        lit_valid[cyc + offs] = v;
        lit_to[cyc + offs]    = t;
    endtask

    task automatic drive(input logic [7:0] r, input logic d);
        @(negedge clk);
        #1;
        req  = r;
        done = d;
    endtask

    initial begin
        int c;
        rst  = 1'b1;
        req  = 8'h00;
        done = 1'b0;
        expect_at(1, 8'h00, 3'd0, 1'b0, 1'b0);
        expect_at(2, 8'h00, 3'd0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;

        drive(8'h00, 1'b0); expect_at(1, 8'h00, 3'd0, 1'b0, 1'b0);

        // Fixed priority and done release
        drive(8'hA0, 1'b0); expect_at(1, 8'h20, 3'd5, 1'b1, 1'b0);
        drive(8'hA0, 1'b0); expect_at(1, 8'h20, 3'd5, 1'b1, 1'b0);
        drive(8'hA0, 1'b1); expect_at(1, 8'h00, 3'd5, 1'b0, 1'b0);
        drive(8'h80, 1'b0); expect_at(1, 8'h80, 3'd7, 1'b1, 1'b0);
        drive(8'h00, 1'b0); expect_at(1, 8'h00, 3'd7, 1'b0, 1'b0);

        // Hold limit reached: 4 valid cycles, timeout pulse, re-grant
        drive(8'h04, 1'b0); expect_at(1, 8'h04, 3'd2, 1'b1, 1'b0);
        repeat (3) begin
            drive(8'h04, 1'b0); expect_at(1, 8'h04, 3'd2, 1'b1, 1'b0);
        end
        drive(8'h04, 1'b0); expect_at(1, 8'h00, 3'd2, 1'b0, 1'b1);
        drive(8'h04, 1'b0); expect_at(1, 8'h04, 3'd2, 1'b1, 1'b0);

        // done coinciding with the hold limit: no timeout
        repeat (3) begin
            drive(8'h04, 1'b0); expect_at(1, 8'h04, 3'd2, 1'b1, 1'b0);
        end
        drive(8'h04, 1'b1); expect_at(1, 8'h00, 3'd2, 1'b0, 1'b0);

        // Owner drop with other requests changing mid-grant
        drive(8'h40, 1'b0); expect_at(1, 8'h40, 3'd6, 1'b1, 1'b0);
        drive(8'h42, 1'b0); expect_at(1, 8'h40, 3'd6, 1'b1, 1'b0);
        drive(8'h02, 1'b0); expect_at(1, 8'h00, 3'd6, 1'b0, 1'b0);
        drive(8'h02, 1'b0); expect_at(1, 8'h02, 3'd1, 1'b1, 1'b0);
        drive(8'h00, 1'b0); expect_at(1, 8'h00, 3'd1, 1'b0, 1'b0);

        // Reset while owner 3 holds the grant
        drive(8'h08, 1'b0); expect_at(1, 8'h08, 3'd3, 1'b1, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        expect_at(0, 8'h00, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        rst  = 1'b0;
        req  = 8'hFF;
        done = 1'b0;
        expect_at(1, 8'h01, 3'd0, 1'b1, 1'b0);
        drive(8'hFF, 1'b1); expect_at(1, 8'h00, 3'd0, 1'b0, 1'b0);

        // All requesting, done pulsed once per grant
        for (int i = 1; i <= 8; i++) begin
`ifdef ARBITER_ROUND_ROBIN_EN
            c = i % 8;
`else
            c = 0;
`endif
            drive(8'hFF, 1'b0); expect_at(1, onehot_of(c), 3'(c), 1'b1, 1'b0);
            drive(8'hFF, 1'b1); expect_at(1, 8'h00, 3'(c), 1'b0, 1'b0);
        end

        drive(8'h00, 1'b0);
        drive(8'h00, 1'b0);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, mis_count);
        $finish;
    end

endmodule
